// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sequencing controller.
package cordic_pkg;

   // Width of the iteration counter shared with the datapath.
   localparam int CNT_W = 4;

   // Datapath input-mux selections.
   localparam logic [1:0] MUX_INIT = 2'b00;
   localparam logic [1:0] MUX_LOOP = 2'b01;
   localparam logic [1:0] MUX_EXT  = 2'b10;
   localparam logic [1:0] MUX_HOLD = 2'b11;

   // Operation modes as seen by the datapath.
   localparam logic MODE_ROT = 1'b0;
   localparam logic MODE_VEC = 1'b1;

   // Controller phases.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      ITER = 2'b10,
      DONE = 2'b11
   } state_t;

endpackage

// File: rtl/cordic_ctl.sv
// CORDIC sequencing controller: steps the datapath through load and
// iteration phases, cross-checks the datapath counter against a local
// shadow copy, and hands the result to the host with a held done flag.
module cordic_ctl
   import cordic_pkg::*;
#(
   parameter int ITERATIONS = 8
)
(
   input  logic             clka,
   input  logic             rst,
   input  logic             start,
   input  logic             mode_in,
   input  logic             ack,
   input  logic [CNT_W-1:0] counter,
   output logic             cordic_mode,
   output logic [1:0]       in_mux_ctl,
   output logic             counter_rst,
   output logic             counter_hold,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERATIONS - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] shadow_nxt;
   logic             mode_nxt;
   logic             err_nxt;

   // State, shadow counter, latched mode and error flag; reset drops any
   // operation in flight without flagging it.
   always_ff @(posedge clka) begin
      if (rst) begin
         state       <= IDLE;
         shadow      <= '0;
         cordic_mode <= MODE_ROT;
         err         <= 1'b0;
      end else begin
         state       <= state_nxt;
         shadow      <= shadow_nxt;
         cordic_mode <= mode_nxt;
         err         <= err_nxt;
      end
   end

   // Next-state logic: ITER ends early on a counter mismatch, otherwise
   // after the shadow counter reaches its last value.
   always_comb begin
      state_nxt  = state;
      shadow_nxt = shadow;
      mode_nxt   = cordic_mode;
      err_nxt    = err;
      case (state)
         IDLE: begin
            if (start) begin
               mode_nxt  = mode_in;
               err_nxt   = 1'b0;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            shadow_nxt = '0;
            state_nxt  = ITER;
         end
         ITER: begin
            shadow_nxt = shadow + ONE;
            if (counter != shadow) begin
               err_nxt   = 1'b1;
               state_nxt = DONE;
            end else if (shadow == LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (ack) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Moore output decode; only the LOAD mux select looks at the latched mode.
   always_comb begin
      in_mux_ctl   = MUX_HOLD;
      counter_rst  = 1'b1;
      counter_hold = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state)
         IDLE: begin
            in_mux_ctl  = MUX_HOLD;
            counter_rst = 1'b1;
         end
         LOAD: begin
            in_mux_ctl  = (cordic_mode == MODE_VEC) ? MUX_EXT : MUX_INIT;
            counter_rst = 1'b1;
            busy        = 1'b1;
         end
         ITER: begin
            in_mux_ctl  = MUX_LOOP;
            counter_rst = 1'b0;
            busy        = 1'b1;
         end
         DONE: begin
            in_mux_ctl   = MUX_HOLD;
            counter_rst  = 1'b0;
            counter_hold = 1'b1;
            done         = 1'b1;
         end
         default: begin
            in_mux_ctl = MUX_HOLD;
         end
      endcase
   end

endmodule

// File: tb/tb_cordic_ctl.sv
// Self-checking bench for cordic_ctl: a directed vector table, hand-written
// corner sequences and randomized operations against a transaction-level model.
module tb_cordic_ctl;

   localparam int ITER_N = 8;

   typedef enum int {P_IDLE, P_LOAD, P_ITER, P_DONE} phase_t;

   typedef struct {
      logic        rst;
      logic        start;
      logic        mode_in;
      logic        ack;
      logic [7:0]  exp;
      string       name;
   } vec_t;

   logic       clka;
   logic       rst;
   logic       start;
   logic       mode_in;
   logic       ack;
   logic [3:0] counter;
   logic       cordic_mode;
   logic [1:0] in_mux_ctl;
   logic       counter_rst;
   logic       counter_hold;
   logic       busy;
   logic       done;
   logic       err;

   int         n_checks;
   int         n_pass;
   logic [3:0] dp_cnt;
   logic [3:0] dp_stall;
   logic       model_mode;
   logic       model_err;
   vec_t       vecs[$];

   cordic_ctl #(.ITERATIONS(ITER_N)) dut (
      .clka         (clka),
      .rst          (rst),
      .start        (start),
      .mode_in      (mode_in),
      .ack          (ack),
      .counter      (counter),
      .cordic_mode  (cordic_mode),
      .in_mux_ctl   (in_mux_ctl),
      .counter_rst  (counter_rst),
      .counter_hold (counter_hold),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   // Free-running controller clock.
   initial clka = 1'b0;
   always #5 clka = ~clka;

   // Expected output vector {mode, mux, rst, hold, busy, done, err} per phase.
   function automatic logic [7:0] exp_out(input phase_t p, input logic m, input logic e);
      case (p)
         P_IDLE:  return {m, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, e};
         P_LOAD:  return {m, (m ? 2'b10 : 2'b00), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
         P_ITER:  return {m, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
         default: return {m, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, e};
      endcase
   endfunction

   // One clock: the datapath counter model reacts to the controls seen before
   // the edge, and all sampling happens 1 time unit after the edge.
   task automatic tick();
      logic r;
      logic h;
      r = counter_rst;
      h = counter_hold;
      @(posedge clka);
      #1;
      if (r === 1'b1) dp_cnt = 4'd0;
      else if (h === 1'b0 && dp_cnt != dp_stall) dp_cnt = dp_cnt + 4'd1;
      counter = dp_cnt;
   endtask

   task automatic applyStimulus(input vec_t v);
      rst     = v.rst;
      start   = v.start;
      mode_in = v.mode_in;
      ack     = v.ack;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] exp);
      logic [7:0] got;
      got = {cordic_mode, in_mux_ctl, counter_rst, counter_hold, busy, done, err};
      n_checks++;
      if (got === exp) n_pass++;
      else $display("[TB] FAIL %s: got mode/mux/rst/hold/busy/done/err=%b/%b/%b/%b/%b/%b/%b required %b/%b/%b/%b/%b/%b/%b",
                    name, got[7], got[6:5], got[4], got[3], got[2], got[1], got[0],
                    exp[7], exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
   endtask

   task automatic push_vec(input logic r, input logic s, input logic m, input logic a,
                           input logic [7:0] e, input string n);
      vec_t v;
      v.rst = r; v.start = s; v.mode_in = m; v.ack = a; v.exp = e; v.name = n;
      vecs.push_back(v);
   endtask

   // One complete operation from IDLE. stall_val >= ITER_N-1 never causes a
   // mismatch. noise: 0 quiet, 1 random start/ack/mode while busy, 2 start held high.
   task automatic run_op(input logic mode, input int stall_val, input int ack_delay,
                         input int noise, input logic ack_with_start, input string tag);
      logic exp_err;
      int   n_iter;
      dp_stall = 4'(stall_val > 15 ? 15 : stall_val);
      exp_err  = (stall_val <= ITER_N - 2);
      n_iter   = exp_err ? stall_val + 2 : ITER_N;
      start = 1'b1; mode_in = mode; ack = 1'b0;
      tick();
      model_mode = mode;
      model_err  = 1'b0;
      checkOutput({tag, " load"}, exp_out(P_LOAD, model_mode, 1'b0));
      for (int i = 0; i <= n_iter; i++) begin
         if (noise == 1) begin
            start   = 1'($urandom_range(0, 1));
            ack     = 1'($urandom_range(0, 1));
            mode_in = 1'($urandom_range(0, 1));
         end else begin
            start = (noise == 2);
            ack   = 1'b0;
         end
         tick();
         if (i < n_iter) checkOutput({tag, " iter"}, exp_out(P_ITER, model_mode, 1'b0));
      end
      model_err = exp_err;
      checkOutput({tag, " done entry"}, exp_out(P_DONE, model_mode, model_err));
      ack = 1'b0;
      for (int d = 0; d < ack_delay; d++) begin
         start = (noise == 2) || (noise == 1 && $urandom_range(0, 1) == 1);
         tick();
         checkOutput({tag, " done held"}, exp_out(P_DONE, model_mode, model_err));
      end
      ack = 1'b1; start = ack_with_start;
      tick();
      checkOutput({tag, " ack to idle"}, exp_out(P_IDLE, model_mode, model_err));
      ack = 1'b0; start = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      rst = 1'b1; start = 1'b0; mode_in = 1'b0; ack = 1'b0;
      dp_cnt = 4'd0; counter = 4'd0; dp_stall = 4'd15;
      model_mode = 1'b0; model_err = 1'b0;

      // Directed table: reset, quiet idle, one rotation of 8 iterations.
      push_vec(1, 0, 0, 0, exp_out(P_IDLE, 0, 0), "reset");
      push_vec(1, 0, 0, 0, exp_out(P_IDLE, 0, 0), "reset");
      for (int i = 0; i < 5; i++) push_vec(0, 0, 1, 0, exp_out(P_IDLE, 0, 0), "idle quiet");
      push_vec(0, 1, 0, 0, exp_out(P_LOAD, 0, 0), "rot load");
      for (int i = 0; i < ITER_N; i++) push_vec(0, 0, 1, 0, exp_out(P_ITER, 0, 0), "rot iter");
      push_vec(0, 0, 0, 0, exp_out(P_DONE, 0, 0), "rot done entry");
      for (int i = 0; i < 3; i++) push_vec(0, 0, 0, 0, exp_out(P_DONE, 0, 0), "rot done held");
      push_vec(0, 0, 0, 1, exp_out(P_IDLE, 0, 0), "rot ack");
      push_vec(0, 0, 0, 0, exp_out(P_IDLE, 0, 0), "rot idle after");
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         tick();
         checkOutput(vecs[i].name, vecs[i].exp);
      end
      start = 1'b0; ack = 1'b0;

      // Vectoring with start held high while busy: must not retrigger.
      run_op(1'b1, 15, 2, 2, 1'b0, "vec start noise");
      tick();
      checkOutput("no extra load", exp_out(P_IDLE, model_mode, model_err));

      // Datapath counter stalls at 3: error, then the next start clears it.
      run_op(1'b0, 3, 1, 0, 1'b0, "stall3");
      tick();
      checkOutput("err held in idle", exp_out(P_IDLE, model_mode, model_err));
      run_op(1'b1, 15, 0, 0, 1'b0, "clear err");

      // Error flag also cleared by reset while idle.
      run_op(1'b1, 0, 0, 0, 1'b0, "stall0");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_mode = 1'b0; model_err = 1'b0;
      checkOutput("reset clears err", exp_out(P_IDLE, 0, 0));

      // Reset during the fourth ITER cycle.
      dp_stall = 4'd15;
      start = 1'b1; mode_in = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("rst seq load", exp_out(P_LOAD, 1'b1, 1'b0));
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("rst seq iter", exp_out(P_ITER, 1'b1, 1'b0));
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_mode = 1'b0; model_err = 1'b0;
      checkOutput("mid-op reset", exp_out(P_IDLE, 0, 0));
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("post reset idle", exp_out(P_IDLE, 0, 0));
      end

      // start together with ack in DONE goes to IDLE; start next cycle loads.
      run_op(1'b0, 15, 1, 0, 1'b1, "start+ack");
      run_op(1'b1, 15, 0, 0, 1'b0, "restart");

      // Randomized operations with random gaps, stalls, noise and ack timing.
      for (int k = 0; k < 40; k++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            ack = 1'($urandom_range(0, 1));
            start = 1'b0;
            tick();
            checkOutput("rand idle gap", exp_out(P_IDLE, model_mode, model_err));
         end
         ack = 1'b0;
         run_op(1'($urandom_range(0, 1)), $urandom_range(0, ITER_N + 2),
                $urandom_range(0, 4), 1, 1'($urandom_range(0, 1)), "rand");
      end

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
